bcd_to_binary: RTL and testbench

Iterative packed-BCD to unsigned binary converter, the inverse of the binary-to-BCD digit accumulator chain. It accepts a DIGITS-digit packed BCD word on a start strobe and runs reverse double-dabble, one bit per clock: shift right, then subtract 3 from every digit ≥ 8. It returns the binary value with a one-cycle done pulse. It sits on the decimal-entry path, where keypad or display-side BCD values are turned back into binary operands.

---
 rtl/bcd_to_binary.sv | 134 +++++++++++++
 tb/tb_bcd_to_binary.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Iterative packed-BCD to unsigned binary converter (reverse double-dabble).
// One bit per clock: shift {bcd_part, bin_part} right, then subtract 3 from
// every BCD digit that is >= 8. Result is presented with a one-cycle done pulse.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to reject operands that
// contain a digit > 9 (err=1, bin_out=0, short IDLE->DONE path).
module bcd_to_binary #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(BW + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     bin_q, bin_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [BIN_W-1:0]  bin_out_q, bin_out_d;
    logic              err_q, err_d;

    logic [2*BW-1:0]   shifted;
    logic [BW-1:0]     bcd_adj;
    logic [3:0]        digit;
    logic              bad_digit;

    // One reverse double-dabble step: shift right, then correct each digit >= 8.
    always_comb begin
        bcd_adj = '0;
        digit   = '0;
        shifted = {bcd_q, bin_q} >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = shifted[BW + 4*i +: 4];
            if (digit >= 4'd8) begin
                digit = digit - 4'd3;
            end
            bcd_adj[4*i +: 4] = digit;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Flag any non-decimal digit in the incoming operand.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    // Next-state logic for the FSM and datapath.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    bin_d = '0;
                    err_d = bad_digit;
                    if (bad_digit) begin
                        // Rejected operand: zero datapath so DONE reports 0.
                        bcd_d   = '0;
                        state_d = StDone;
                    end else begin
                        bcd_d   = bcd_in;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                bcd_d = bcd_adj;
                bin_d = shifted[BW-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d    = 1'b1;
                bin_out_d = BIN_W'(bin_q);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: a 4-digit instance for directed and
// random conversions, and a 2-digit instance swept over all valid operands.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy, done, err;
    logic [13:0] bin_out;

    logic        start2 = 1'b0;
    logic [7:0]  bcd2 = '0;
    logic        busy2, done2, err2;
    logic [6:0]  bin2;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    int cyc, ndone, last, rexp;
    logic [31:0] e;
    logic [15:0] rbcd;

    bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    bcd_to_binary #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand on the 4-digit instance and check its result.
    task automatic conv(input logic [15:0] bcd, input logic [31:0] exp_bin,
                        input logic exp_err, input int exp_lat, input string tag);
        int c;
        int nbusy;
        logic [31:0] ev;
        bcd_in = bcd;
        start  = 1'b1;
        exp_q.push_back(exp_bin);
        tick();
        start  = 1'b0;
        bcd_in = bcd ^ 16'h0777;
        c = 0;
        nbusy = 0;
        while (!done && c < 40) begin
            nbusy += int'(busy);
            tick();
            c++;
        end
        ev = exp_q.pop_front();
        chk({tag, " latency"}, c, exp_lat);
        chk({tag, " value"}, 32'(bin_out), ev);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " busy cycles"}, nbusy, exp_lat);
        tick();
        chk({tag, " done pulse width"}, 32'(done), 0);
    endtask

    // Accept one operand on the 2-digit instance and check its result.
    task automatic conv2(input int v);
        int c;
        logic [31:0] ev;
        bcd2   = 8'((v / 10) * 16 + (v % 10));
        start2 = 1'b1;
        exp_q.push_back(v);
        tick();
        start2 = 1'b0;
        c = 0;
        while (!done2 && c < 20) begin
            tick();
            c++;
        end
        ev = exp_q.pop_front();
        chk("sweep latency", c, 9);
        chk("sweep value", 32'(bin2), ev);
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset bin_out", 32'(bin_out), 0);
        chk("reset err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        conv(16'h1234, 1234, 1'b0, 17, "1234");
        conv(16'h9999, 9999, 1'b0, 17, "9999");
        conv(16'h0000, 0, 1'b0, 17, "0000");

        for (int k = 0; k < 6; k++) begin
            rbcd = '0;
            rexp = 0;
            for (int d = 3; d >= 0; d--) begin
                int dv;
                dv = int'($urandom_range(0, 9));
                rbcd = {rbcd[11:0], 4'(dv)};
                rexp = rexp * 10 + dv;
            end
            conv(rbcd, rexp, 1'b0, 17, "random");
        end

        // Start held high: back-to-back conversions, operand disturbed mid-run.
        bcd_in = 16'h0042;
        start  = 1'b1;
        repeat (3) exp_q.push_back(42);
        tick();
        cyc = 0;
        ndone = 0;
        last = 0;
        while (ndone < 3 && cyc < 80) begin
            if (cyc == 5) bcd_in = 16'h0777;
            if (cyc == 9) bcd_in = 16'h0042;
            if (done) begin
                e = exp_q.pop_front();
                chk("held-start value", 32'(bin_out), e);
                chk("held-start period", cyc - last, (ndone == 0) ? 17 : 18);
                last = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
            if (ndone < 3) begin
                tick();
                cyc++;
            end
        end
        chk("held-start count", ndone, 3);
        tick();

        // Reset in the middle of a conversion aborts it.
        bcd_in = 16'h5678;
        start  = 1'b1;
        exp_q.push_back(5678);
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort bin_out", 32'(bin_out), 0);
        chk("abort err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            ndone += int'(done);
        end
        chk("abort no done", ndone, 0);
        conv(16'h0001, 1, 1'b0, 17, "after abort");

`ifdef BCD2BIN_DIGIT_CHECK_EN
        conv(16'h12A4, 0, 1'b1, 1, "bad digit");
        conv(16'h0010, 10, 1'b0, 17, "after bad digit");
`endif

        for (int v = 0; v < 100; v++) begin
            conv2(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
